discharge_classifier: RTL and testbench
=======================================

DISCHARGE_CLASSIFIER -- requirements
Module: discharge_classifier

Interface
REQ-001 SHALL have parameter V_SHORT_MV, default 16'sd500: gap-voltage limit in mV; below it, a discharge is classed as a short.
REQ-002 SHALL have parameter I_ON_MV, default 16'sd1000: current-channel level in mV at or above which current is flowing.
REQ-003 SHALL have parameter ARC_DELAY_CYC, default 16'd13: ignition delay in cycles below which a breakdown is an arc (13 cycles is about 200 ns at 65 MHz).
REQ-004 SHALL have port ad_clk, input, 1 bit: 65 MHz ADC clock, the only clock.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port pulse_on, input, 1 bit: pulse-generator power-switch enable.
REQ-007 SHALL have port volt_ch1, input, 16 bit signed: board current in mV, two's complement.
REQ-008 SHALL have port volt_ch2, input, 16 bit signed: gap voltage in mV, two's complement.
REQ-009 SHALL have port cnt_clr, input, 1 bit: synchronous clear of the statistics counters.
REQ-010 SHALL have port gap_state, output, 2 bit: class of the last pulse; 0=OPEN, 1=NORMAL, 2=ARC, 3=SHORT.
REQ-011 SHALL have port result_valid, output, 1 bit: one-cycle strobe that gap_state and ignition_delay are updated.
REQ-012 SHALL have port ignition_delay, output, 16 bit unsigned: cycles from pulse start to breakdown.
REQ-013 SHALL have ports open_cnt, normal_cnt, arc_cnt and short_cnt, each output, 16 bit: saturating per-class pulse counts.

Function
REQ-014 SHALL register pulse_on, volt_ch1 and volt_ch2 once (stage S1); all decisions use only the S1 values.
REQ-015 SHALL implement an FSM with states IDLE, WAIT_BD and DISCHARGE; the reset state is IDLE.
REQ-016 SHALL go from IDLE to WAIT_BD when S1 pulse_on=1, and load delay_cnt with 0 on that edge.
REQ-017 SHALL, in WAIT_BD, increment delay_cnt by 1 every cycle, saturating at 16'hFFFF with no wrap.
REQ-018 SHALL, in WAIT_BD, detect breakdown when S1 volt_ch1 >= I_ON_MV (signed compare).
REQ-019 SHALL classify a breakdown by priority: first SHORT if S1 volt_ch2 < V_SHORT_MV (signed); else ARC if delay_cnt < ARC_DELAY_CYC; else NORMAL. It then moves to DISCHARGE.
REQ-020 SHALL, in WAIT_BD with S1 pulse_on=0 and no breakdown, classify OPEN with ignition_delay=16'hFFFF and move to IDLE.
REQ-021 SHALL let breakdown take priority over the OPEN rule when both occur in the same cycle.
REQ-022 SHALL, in DISCHARGE, issue no further result and move to IDLE when S1 pulse_on=0.
REQ-023 SHALL pulse result_valid high for exactly one cycle per classification, in the cycle after the classifying edge; gap_state and ignition_delay update in that same cycle.
REQ-024 SHALL hold gap_state and ignition_delay between results.
REQ-025 SHALL give 2 ad_clk edges of latency from the input-sampling edge to result_valid.
REQ-026 SHALL increment the counter of the matching class on each result_valid, saturating at 16'hFFFF.
REQ-027 SHALL clear all four counters on cnt_clr=1; if result_valid and cnt_clr occur in the same cycle, the matching counter becomes 1 and the others become 0.
REQ-028 SHALL never produce more than one classification per pulse_on high period.

Reset
REQ-029 SHALL, on rst_n=0 and asynchronously, set the FSM to IDLE and clear the S1 registers and delay_cnt to 0.
REQ-030 SHALL, on rst_n=0, set gap_state=0, result_valid=0, ignition_delay=0 and all counters to 0.
REQ-031 SHALL, when reset is asserted mid-pulse, abandon that pulse with no result; after release, a still-high pulse_on starts a fresh WAIT_BD.

Verification
REQ-032 SHALL verify normal discharge: pulse_on rises, volt_ch2=4000, volt_ch1=0 for 50 cycles, then volt_ch1=2000 -> one result_valid with gap_state=1, ignition_delay=50 and normal_cnt=1.
REQ-033 SHALL verify arc: breakdown after 5 cycles with volt_ch2=2000 -> gap_state=2, ignition_delay=5.
REQ-034 SHALL verify short: current 1500 at cycle 30 with volt_ch2=200 -> gap_state=3; SHORT wins over the delay rule.
REQ-035 SHALL verify open: pulse_on high for 100 cycles with volt_ch1=0 -> gap_state=0, ignition_delay=16'hFFFF, open_cnt=1; no result at any later fall of pulse_on.
REQ-036 SHALL verify saturation and clear: 70000 cycles in WAIT_BD -> ignition_delay=16'hFFFF; cnt_clr coincident with an ARC result_valid -> arc_cnt=1, others 0.
REQ-037 SHALL verify reset mid-pulse: rst_n low during DISCHARGE -> all outputs 0, no result_valid, and a fresh classification follows the next pulse.

Source files
------------

// File: rtl/discharge_classifier.sv
// rtl/discharge_classifier.sv - per-pulse gap discharge classifier with saturating class counters
//
// Purpose:
//   Watches one EDM pulse at a time. After the pulse generator is enabled it
//   counts cycles until the board current shows a breakdown. It then classes
//   the pulse as OPEN, NORMAL, ARC or SHORT and keeps a saturating count of
//   each class.
//
// Ports:
//   ad_clk         in   65 MHz ADC clock, the only clock
//   rst_n          in   asynchronous active-low reset
//   pulse_on       in   pulse-generator power-switch enable
//   volt_ch1       in   board current in mV (signed)
//   volt_ch2       in   gap voltage in mV (signed)
//   cnt_clr        in   synchronous clear of the class counters
//   gap_state      out  class of last pulse: 0=OPEN 1=NORMAL 2=ARC 3=SHORT
//   result_valid   out  one-cycle strobe when gap_state/ignition_delay update
//   ignition_delay out  cycles from pulse start to breakdown (FFFF for OPEN)
//   open_cnt       out  saturating OPEN count
//   normal_cnt     out  saturating NORMAL count
//   arc_cnt        out  saturating ARC count
//   short_cnt      out  saturating SHORT count

module discharge_classifier #(
  parameter logic signed [15:0] V_SHORT_MV    = 16'sd500,
  parameter logic signed [15:0] I_ON_MV       = 16'sd1000,
  parameter logic        [15:0] ARC_DELAY_CYC = 16'd13
) (
  input  logic               ad_clk,
  input  logic               rst_n,
  input  logic               pulse_on,
  input  logic signed [15:0] volt_ch1,
  input  logic signed [15:0] volt_ch2,
  input  logic               cnt_clr,
  output logic        [1:0]  gap_state,
  output logic               result_valid,
  output logic        [15:0] ignition_delay,
  output logic        [15:0] open_cnt,
  output logic        [15:0] normal_cnt,
  output logic        [15:0] arc_cnt,
  output logic        [15:0] short_cnt
);

  localparam logic [1:0] CLS_OPEN   = 2'd0;
  localparam logic [1:0] CLS_NORMAL = 2'd1;
  localparam logic [1:0] CLS_ARC    = 2'd2;
  localparam logic [1:0] CLS_SHORT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BD   = 2'd1,
    ST_DISCHARGE = 2'd2
  } state_t;

  // Input stage: every decision below looks only at these registered copies.
  logic               r_s1_pulse_on;
  logic signed [15:0] r_s1_ch1;
  logic signed [15:0] r_s1_ch2;

  state_t             r_state;
  logic        [15:0] r_delay_cnt;
  logic        [1:0]  r_gap_state;
  logic               r_result_valid;
  logic        [15:0] r_ignition_delay;

  logic        [15:0] r_open_cnt;
  logic        [15:0] r_normal_cnt;
  logic        [15:0] r_arc_cnt;
  logic        [15:0] r_short_cnt;

  logic               w_breakdown;
  logic               w_is_short;
  logic               w_is_arc;
  logic        [1:0]  w_bd_class;
  logic        [15:0] w_delay_inc;

  always_ff @(posedge ad_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_pulse_on <= 1'b0;
      r_s1_ch1      <= '0;
      r_s1_ch2      <= '0;
    end else begin
      r_s1_pulse_on <= pulse_on;
      r_s1_ch1      <= volt_ch1;
      r_s1_ch2      <= volt_ch2;
    end
  end

  assign w_breakdown = (r_s1_ch1 >= I_ON_MV);
  assign w_is_short  = (r_s1_ch2 < V_SHORT_MV);
  assign w_is_arc    = (r_delay_cnt < ARC_DELAY_CYC);

  // A collapsed gap voltage outranks the ignition-delay test.
  assign w_bd_class  = w_is_short ? CLS_SHORT :
                       w_is_arc   ? CLS_ARC   : CLS_NORMAL;

  // Saturate instead of wrapping so a very late breakdown reads as FFFF.
  assign w_delay_inc = (r_delay_cnt == 16'hFFFF) ? 16'hFFFF : (r_delay_cnt + 16'd1);

  always_ff @(posedge ad_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= ST_IDLE;
      r_delay_cnt      <= '0;
      r_gap_state      <= CLS_OPEN;
      r_result_valid   <= 1'b0;
      r_ignition_delay <= '0;
    end else begin
      r_result_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_s1_pulse_on) begin
            r_state     <= ST_WAIT_BD;
            r_delay_cnt <= '0;
          end
        end
        ST_WAIT_BD: begin
          // Breakdown is checked first so it wins over a same-cycle pulse end.
          if (w_breakdown) begin
            r_result_valid   <= 1'b1;
            r_gap_state      <= w_bd_class;
            r_ignition_delay <= r_delay_cnt;
            r_state          <= ST_DISCHARGE;
          end else if (!r_s1_pulse_on) begin
            r_result_valid   <= 1'b1;
            r_gap_state      <= CLS_OPEN;
            r_ignition_delay <= 16'hFFFF;
            r_state          <= ST_IDLE;
          end else begin
            r_delay_cnt <= w_delay_inc;
          end
        end
        ST_DISCHARGE: begin
          // The pulse has already been classified; just wait for it to end.
          if (!r_s1_pulse_on) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? 16'hFFFF : (v + 16'd1);
  endfunction

  // A clear coinciding with a result leaves only that result counted.
  always_ff @(posedge ad_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_open_cnt   <= '0;
      r_normal_cnt <= '0;
      r_arc_cnt    <= '0;
      r_short_cnt  <= '0;
    end else if (cnt_clr) begin
      r_open_cnt   <= (r_result_valid && r_gap_state == CLS_OPEN)   ? 16'd1 : 16'd0;
      r_normal_cnt <= (r_result_valid && r_gap_state == CLS_NORMAL) ? 16'd1 : 16'd0;
      r_arc_cnt    <= (r_result_valid && r_gap_state == CLS_ARC)    ? 16'd1 : 16'd0;
      r_short_cnt  <= (r_result_valid && r_gap_state == CLS_SHORT)  ? 16'd1 : 16'd0;
    end else if (r_result_valid) begin
      case (r_gap_state)
        CLS_OPEN:   r_open_cnt   <= sat_inc(r_open_cnt);
        CLS_NORMAL: r_normal_cnt <= sat_inc(r_normal_cnt);
        CLS_ARC:    r_arc_cnt    <= sat_inc(r_arc_cnt);
        default:    r_short_cnt  <= sat_inc(r_short_cnt);
      endcase
    end
  end

  assign gap_state      = r_gap_state;
  assign result_valid   = r_result_valid;
  assign ignition_delay = r_ignition_delay;
  assign open_cnt       = r_open_cnt;
  assign normal_cnt     = r_normal_cnt;
  assign arc_cnt        = r_arc_cnt;
  assign short_cnt      = r_short_cnt;

endmodule

// File: tb/tb_discharge_classifier.sv
// tb/tb_discharge_classifier.sv - self-checking bench for discharge_classifier

module tb_discharge_classifier;

  logic               ad_clk;
  logic               rst_n;
  logic               pulse_on;
  logic signed [15:0] volt_ch1;
  logic signed [15:0] volt_ch2;
  logic               cnt_clr;
  logic        [1:0]  gap_state;
  logic               result_valid;
  logic        [15:0] ignition_delay;
  logic        [15:0] open_cnt;
  logic        [15:0] normal_cnt;
  logic        [15:0] arc_cnt;
  logic        [15:0] short_cnt;

  discharge_classifier dut (
    .ad_clk         (ad_clk),
    .rst_n          (rst_n),
    .pulse_on       (pulse_on),
    .volt_ch1       (volt_ch1),
    .volt_ch2       (volt_ch2),
    .cnt_clr        (cnt_clr),
    .gap_state      (gap_state),
    .result_valid   (result_valid),
    .ignition_delay (ignition_delay),
    .open_cnt       (open_cnt),
    .normal_cnt     (normal_cnt),
    .arc_cnt        (arc_cnt),
    .short_cnt      (short_cnt)
  );

  initial ad_clk = 1'b0;
  always #5 ad_clk = ~ad_clk;

  int n_assert = 0;
  int n_fail   = 0;
  int rv_seen  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: tracks the pulse as "not started / waiting for current /
  // current flowing" with an unbounded elapsed-cycle count, and derives the
  // result from the classification rules. Inputs are seen one cycle late.
  int m_phase, m_elapsed, m_c1, m_c2;
  bit m_p;
  bit e_rv;
  int e_gs, e_dly;
  int e_cnt[4];
  bit prev_rv;
  int prev_gs;

  always @(posedge ad_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_elapsed = 0; m_p = 0; m_c1 = 0; m_c2 = 0;
      e_rv = 0; e_gs = 0; e_dly = 0;
      for (int k = 0; k < 4; k++) e_cnt[k] = 0;
    end else begin
      prev_rv = e_rv;
      prev_gs = e_gs;
      e_rv = 0;
      if (m_phase == 0) begin
        if (m_p) begin m_phase = 1; m_elapsed = 0; end
      end else if (m_phase == 1) begin
        if (m_c1 >= 1000) begin
          e_rv  = 1;
          e_dly = (m_elapsed > 65535) ? 65535 : m_elapsed;
          e_gs  = (m_c2 < 500) ? 3 : (m_elapsed < 13) ? 2 : 1;
          m_phase = 2;
        end else if (!m_p) begin
          e_rv = 1; e_gs = 0; e_dly = 65535; m_phase = 0;
        end else begin
          m_elapsed++;
        end
      end else begin
        if (!m_p) m_phase = 0;
      end
      if (cnt_clr) for (int k = 0; k < 4; k++) e_cnt[k] = 0;
      if (prev_rv) e_cnt[prev_gs] = (e_cnt[prev_gs] >= 65535) ? 65535 : e_cnt[prev_gs] + 1;
      m_p  = pulse_on;
      m_c1 = volt_ch1;
      m_c2 = volt_ch2;
    end
  end

  always @(negedge ad_clk) begin
    chk("model_result_valid", {31'd0, result_valid}, {31'd0, e_rv});
    if (e_rv) begin
      chk("model_gap_state", {30'd0, gap_state}, e_gs);
      chk("model_ignition_delay", {16'd0, ignition_delay}, e_dly);
    end
    chk("model_open_cnt",   {16'd0, open_cnt},   e_cnt[0]);
    chk("model_normal_cnt", {16'd0, normal_cnt}, e_cnt[1]);
    chk("model_arc_cnt",    {16'd0, arc_cnt},    e_cnt[2]);
    chk("model_short_cnt",  {16'd0, short_cnt},  e_cnt[3]);
    if (result_valid) rv_seen++;
  end

  logic [1:0]  cap_gs;
  logic [15:0] cap_dly;
  bit          clr_on_result;

  task automatic tick(input int n);
    repeat (n) @(posedge ad_clk);
    #1;
  endtask

  // Waits (bounded) for the next result strobe and captures it.
  task automatic wait_result(input string name);
    bit got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge ad_clk);
      if (result_valid) begin
        got = 1;
        cap_gs  = gap_state;
        cap_dly = ignition_delay;
        if (clr_on_result) cnt_clr = 1'b1;
      end
    end
    chk({name, "_timeout"}, {31'd0, got}, 32'd1);
    if (clr_on_result) begin
      @(posedge ad_clk); #1;
      cnt_clr = 1'b0;
      clr_on_result = 0;
    end
  endtask

  // Pulse starts, one arming cycle, wait_cyc cycles of no current, then the hit.
  task automatic breakdown_pulse(input int wait_cyc, input int c1, input int c2, input string name);
    pulse_on = 1'b1; volt_ch1 = 16'sd0; volt_ch2 = c2[15:0];
    tick(1 + wait_cyc);
    volt_ch1 = c1[15:0];
    wait_result(name);
  endtask

  task automatic end_pulse;
    tick(5);
    pulse_on = 1'b0; volt_ch1 = 16'sd0;
    tick(10);
  endtask

  int rv0;

  initial begin
    rst_n = 1'b0; pulse_on = 1'b0; volt_ch1 = '0; volt_ch2 = '0; cnt_clr = 1'b0;
    clr_on_result = 0;
    tick(3);
    chk("reset_gap_state", {30'd0, gap_state}, 32'd0);
    chk("reset_result_valid", {31'd0, result_valid}, 32'd0);
    chk("reset_ignition_delay", {16'd0, ignition_delay}, 32'd0);
    chk("reset_counters", {open_cnt | normal_cnt | arc_cnt | short_cnt}, 32'd0);
    rst_n = 1'b1;
    tick(3);

    // Normal discharge
    rv0 = rv_seen;
    breakdown_pulse(50, 2000, 4000, "normal");
    chk("normal_gap_state", {30'd0, cap_gs}, 32'd1);
    chk("normal_delay", {16'd0, cap_dly}, 32'd50);
    end_pulse();
    chk("normal_cnt", {16'd0, normal_cnt}, 32'd1);
    chk("normal_one_result", rv_seen - rv0, 32'd1);

    // Arc
    breakdown_pulse(5, 2000, 2000, "arc");
    chk("arc_gap_state", {30'd0, cap_gs}, 32'd2);
    chk("arc_delay", {16'd0, cap_dly}, 32'd5);
    end_pulse();

    // Short, late enough that the delay rule alone would say NORMAL
    breakdown_pulse(30, 1500, 200, "short");
    chk("short_gap_state", {30'd0, cap_gs}, 32'd3);
    chk("short_delay", {16'd0, cap_dly}, 32'd30);
    end_pulse();

    // Open
    rv0 = rv_seen;
    pulse_on = 1'b1; volt_ch1 = 16'sd0; volt_ch2 = 16'sd4000;
    tick(100);
    pulse_on = 1'b0;
    wait_result("open");
    chk("open_gap_state", {30'd0, cap_gs}, 32'd0);
    chk("open_delay", {16'd0, cap_dly}, 32'hFFFF);
    tick(20);
    chk("open_cnt", {16'd0, open_cnt}, 32'd1);
    chk("open_one_result", rv_seen - rv0, 32'd1);
    chk("counts_after_four", {arc_cnt[7:0], short_cnt[7:0], normal_cnt[7:0], open_cnt[7:0]},
        32'h01010101);

    // Delay counter saturation
    breakdown_pulse(70000, 2000, 4000, "saturate");
    chk("sat_gap_state", {30'd0, cap_gs}, 32'd1);
    chk("sat_delay", {16'd0, cap_dly}, 32'hFFFF);
    end_pulse();
    chk("sat_normal_cnt", {16'd0, normal_cnt}, 32'd2);

    // Clear coincident with an ARC result
    clr_on_result = 1;
    breakdown_pulse(3, 2000, 2000, "arc_clr");
    chk("arc_clr_gap_state", {30'd0, cap_gs}, 32'd2);
    chk("arc_clr_arc_cnt", {16'd0, arc_cnt}, 32'd1);
    chk("arc_clr_others", {open_cnt | normal_cnt | short_cnt}, 32'd0);
    end_pulse();

    // Reset during DISCHARGE, pulse_on kept high through the reset
    breakdown_pulse(20, 2000, 4000, "pre_reset");
    tick(4);
    volt_ch1 = 16'sd0;
    #2 rst_n = 1'b0;
    rv0 = rv_seen;
    @(negedge ad_clk);
    chk("midrst_gap_state", {30'd0, gap_state}, 32'd0);
    chk("midrst_delay", {16'd0, ignition_delay}, 32'd0);
    chk("midrst_counters", {open_cnt | normal_cnt | arc_cnt | short_cnt}, 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(21);
    chk("midrst_no_result", rv_seen - rv0, 32'd0);
    volt_ch1 = 16'sd2000;
    wait_result("post_reset");
    chk("post_reset_gap_state", {30'd0, cap_gs}, 32'd1);
    chk("post_reset_delay", {16'd0, cap_dly}, 32'd20);
    end_pulse();
    chk("post_reset_normal_cnt", {16'd0, normal_cnt}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
